clock_mux_switch_ctrl: RTL

CLOCK_MUX_SWITCH_CTRL -- requirements
Module: clock_mux_switch_ctrl

---
 rtl/clock_mux_pkg.sv | 25 ++
 rtl/clock_mux_settle_timer.sv | 30 +++
 rtl/clock_mux_switch_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/clock_mux_pkg.sv
// Shared definitions for the clock-mux switch controller: FSM encoding,
// response status codes and source select values.
package clock_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] STAT_OK       = 2'b00;
  localparam logic [1:0] STAT_REJECTED = 2'b01;
  localparam logic [1:0] STAT_NOP      = 2'b10;
  localparam logic [1:0] STAT_FAILOVER = 2'b11;

  localparam logic SEL_CLK1 = 1'b0;
  localparam logic SEL_CLK2 = 1'b1;

  // Presence bit of the source addressed by sel.
  function automatic logic src_ok(input logic sel, input logic ok1, input logic ok2);
    return (sel == SEL_CLK2) ? ok2 : ok1;
  endfunction

endpackage

// File: rtl/clock_mux_settle_timer.sv
// Down-counter that times the settle window after a mux select change.
// done is high whenever the count has reached zero.
module clock_mux_settle_timer #(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Load on entry to settle, then step down once per cycle, parking at zero.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (count && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/clock_mux_switch_ctrl.sv
// Request/response controller for a glitchless two-input clock mux. It
// validates switch requests, drives the mux select, holds a settle window
// after every change and fails over autonomously when the active source dies.
import clock_mux_pkg::*;

module clock_mux_switch_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter bit AUTO_FAILOVER = 1'b1
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_sel,
  input  logic       clk1_ok,
  input  logic       clk2_ok,
  output logic       selection,
  output logic       switching,
  output logic       rsp_valid,
  output logic [1:0] rsp_status
);

  state_t state;
  logic   tgt_q;
  logic   fo_take;
  logic   accept;
  logic   check_go;
  logic   tmr_done;

  // Failover wins over a pending request: the active source is gone and the
  // other one is present, so ready is withheld on that cycle.
  assign fo_take   = AUTO_FAILOVER && (state == ST_IDLE) &&
                     !src_ok(selection, clk1_ok, clk2_ok) &&
                      src_ok(~selection, clk1_ok, clk2_ok);
  assign req_ready = (state == ST_IDLE) && !areset && !fo_take;
  assign accept    = req_valid && req_ready;
  assign check_go  = (state == ST_CHECK) && (tgt_q != selection) &&
                     src_ok(tgt_q, clk1_ok, clk2_ok);

  clock_mux_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (aclk),
    .rst  (areset),
    .load (check_go || fo_take),
    .count(state == ST_SETTLE),
    .done (tmr_done)
  );

  // Controller FSM with registered select, settle flag and response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      tgt_q      <= SEL_CLK1;
      selection  <= SEL_CLK1;
      switching  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= STAT_OK;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fo_take) begin
            selection  <= ~selection;
            rsp_status <= STAT_FAILOVER;
            switching  <= 1'b1;
            state      <= ST_SETTLE;
          end else if (accept) begin
            tgt_q <= req_sel;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (tgt_q == selection) begin
            rsp_status <= STAT_NOP;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else if (!src_ok(tgt_q, clk1_ok, clk2_ok)) begin
            rsp_status <= STAT_REJECTED;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            selection  <= tgt_q;
            rsp_status <= STAT_OK;
            switching  <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            switching <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
